// File: rtl/regfile_fwd_if.sv
// Bus interface for regfile_fwd: read ports, WB write port, forwarding
// stage buses and the load-use stall flag. The ID-stage controller drives
// the master side; the register file is the slave.
interface regfile_fwd_if #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NFWD = 3
);
    logic [NRD-1:0]             ren;
    logic [NRD*AW-1:0]          raddr;
    logic [NRD*DW-1:0]          rdata;
    logic                       we;
    logic [AW-1:0]              waddr;
    logic [DW-1:0]              wdata;
    logic [NFWD*(DW+AW+2)-1:0]  fwd_bus;
    logic                       stall;

    modport master (
        output ren, raddr, we, waddr, wdata, fwd_bus,
        input  rdata, stall
    );

    modport slave (
        input  ren, raddr, we, waddr, wdata, fwd_bus,
        output rdata, stall
    );
endinterface

// File: rtl/regfile_fwd.sv
// regfile_fwd: GPR file for the 5-stage pipeline, sitting in ID.
// NRD combinational read ports, one WB write port, register 0 hard-wired
// to zero. Read priority per port: zero register, forwarding stages
// (youngest first), WB write-through, then the array.
// Macro RF_FWD_EN: when defined, the forwarding network and load-use stall
// are built; when undefined, fwd_bus is ignored, stall is 0 and reads fall
// back to zero-register / write-through / array.
module regfile_fwd #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NFWD = 3
) (
    input  logic          clk,
    input  logic          resetn,
    regfile_fwd_if.slave  bus
);
    localparam int NREG = 1 << AW;
    // One stage bus slot: {we, rdy, waddr, wdata}
    localparam int SW   = DW + AW + 2;

    logic [DW-1:0]     regs [NREG];
    logic [NRD*DW-1:0] rdata_c;
`ifdef RF_FWD_EN
    logic [NRD-1:0]    hazard;
`endif

    // WB write into the array; asynchronous clear of every register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the whole array is reset on purpose -- software relies on GPRs reading 0 after reset.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (bus.we && (bus.waddr != '0)) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Per-port read resolution, first hit wins
    always_comb begin : read_mux
        logic [AW-1:0] ra;
        logic          hit;
`ifdef RF_FWD_EN
        logic [SW-1:0] st;
`endif
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        rdata_c = '0;
        ra      = '0;
        hit     = 1'b0;
`ifdef RF_FWD_EN
        hazard  = '0;
        st      = '0;
`endif
        for (int r = 0; r < NRD; r++) begin
            // NOTE: blocking assignments here -- later lines read the values just computed.
            ra  = bus.raddr[r*AW +: AW];
            hit = (ra == '0);
`ifdef RF_FWD_EN
            for (int s = 0; s < NFWD; s++) begin
                st = bus.fwd_bus[s*SW +: SW];
                if (!hit && st[SW-1] && (st[DW +: AW] != '0) && (st[DW +: AW] == ra)) begin
                    hit = 1'b1;
                    if (st[SW-2]) rdata_c[r*DW +: DW] = st[DW-1:0];
                    else          hazard[r] = 1'b1;
                end
            end
`endif
            if (!hit && bus.we && (bus.waddr == ra)) begin
                hit = 1'b1;
                rdata_c[r*DW +: DW] = bus.wdata;
            end
            if (!hit) begin
                rdata_c[r*DW +: DW] = resetn ? regs[ra] : '0;
            end
        end
    end

    assign bus.rdata = rdata_c;

`ifdef RF_FWD_EN
    // Load-use stall: only enabled ports may stall the front end
    assign bus.stall = |(bus.ren & hazard);
`else
    // Forwarding network absent: control unit inserts bubbles instead
    assign bus.stall = 1'b0;
    logic unused_fwd;
    assign unused_fwd = ^{bus.fwd_bus, bus.ren};
`endif
endmodule

// File: tb/tb_regfile_fwd.sv
// Directed testbench for regfile_fwd. Expected values are hand-computed;
// where the forwarding network changes the answer, both outcomes are
// written out and selected by RF_FWD_EN.
module tb_regfile_fwd;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NFWD = 3;
    localparam int SW   = DW + AW + 2;
`ifdef RF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_bad;

    regfile_fwd_if #(.DW(DW), .AW(AW), .NRD(NRD), .NFWD(NFWD)) bus ();

    regfile_fwd #(.DW(DW), .AW(AW), .NRD(NRD), .NFWD(NFWD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_fwd(input int s, input logic we, input logic rdy,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.fwd_bus[s*SW +: SW] = {we, rdy, a, d};
    endtask

    task automatic set_raddr(input int r, input logic [AW-1:0] a);
        bus.raddr[r*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rd(input int r);
        return bus.rdata[r*DW +: DW];
    endfunction

    // Write through the WB port across one rising edge
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
        @(negedge clk);
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        resetn = 1'b0;
        bus.ren = '0; bus.raddr = '0; bus.we = 1'b0;
        bus.waddr = '0; bus.wdata = '0; bus.fwd_bus = '0;
        #25 resetn = 1'b1;

        // Reset state
        @(negedge clk);
        set_raddr(0, 5'd5); set_raddr(1, 5'd31); #1;
        check("rst_r5", rd(0), 32'h0);
        check("rst_r31", rd(1), 32'h0);
        check("rst_stall", {31'b0, bus.stall}, 32'h0);

        // 1. asynchronous reset clears a written register immediately
        do_write(5'd5, 32'h1234);
        #1 check("wr_r5", rd(0), 32'h1234);
        #3 resetn = 1'b0;
        #1 check("async_clr_r5", rd(0), 32'h0);
        // write-through still visible while in reset
        bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h5; set_raddr(1, 5'd7);
        #1 check("rst_wthru", rd(1), 32'h5);
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        #1 resetn = 1'b1;
        @(negedge clk); @(negedge clk);
        #1 check("post_rst_r5", rd(0), 32'h0);
        check("post_rst_r7", rd(1), 32'h0);

        // 2. same-cycle write-through, then stored value
        @(negedge clk);
        bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hDEADBEEF;
        set_raddr(0, 5'd7); set_raddr(1, 5'd7);
        #1 check("wthru_p0", rd(0), 32'hDEADBEEF);
        @(negedge clk);
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        #1 check("stored_p0", rd(0), 32'hDEADBEEF);
        check("stored_p1", rd(1), 32'hDEADBEEF);

        // 3. register zero
        @(negedge clk);
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
        set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hAAAA);
        bus.ren = 2'b11; set_raddr(0, 5'd0); set_raddr(1, 5'd0);
        #1 check("zero_p0", rd(0), 32'h0);
        check("zero_p1", rd(1), 32'h0);
        check("zero_stall", {31'b0, bus.stall}, 32'h0);
        @(negedge clk);
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.fwd_bus = '0;
        #1 check("zero_after_wr", rd(0), 32'h0);

        // 4. forwarding priority
        do_write(5'd3, 32'h1);
        set_fwd(2, 1'b1, 1'b1, 5'd3, 32'h30);
        set_fwd(1, 1'b1, 1'b1, 5'd3, 32'h20);
        set_fwd(0, 1'b1, 1'b1, 5'd3, 32'h10);
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h40;
        bus.ren = 2'b01; set_raddr(0, 5'd3); set_raddr(1, 5'd3);
        #1 check("prio_s0", rd(0), FWD ? 32'h10 : 32'h40);
        check("prio_s0_p1", rd(1), FWD ? 32'h10 : 32'h40);
        set_fwd(0, 1'b0, 1'b1, 5'd3, 32'h10);
        #1 check("prio_s1", rd(0), FWD ? 32'h20 : 32'h40);
        set_fwd(1, 1'b0, 1'b1, 5'd3, 32'h20);
        #1 check("prio_s2", rd(0), FWD ? 32'h30 : 32'h40);
        bus.fwd_bus = '0;
        #1 check("prio_wb", rd(0), 32'h40);
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        #1 check("prio_reg", rd(0), 32'h1);

        // 5. load-use hazard
        do_write(5'd9, 32'h99);
        set_fwd(0, 1'b1, 1'b0, 5'd9, 32'h77);
        bus.ren = 2'b01; set_raddr(0, 5'd9); set_raddr(1, 5'd0);
        #1 check("lu_stall", {31'b0, bus.stall}, FWD ? 32'h1 : 32'h0);
        check("lu_data", rd(0), FWD ? 32'h0 : 32'h99);
        bus.ren = 2'b00;
        #1 check("lu_ren0_stall", {31'b0, bus.stall}, 32'h0);
        bus.ren = 2'b10; set_raddr(0, 5'd0); set_raddr(1, 5'd9);
        #1 check("lu_p1_stall", {31'b0, bus.stall}, FWD ? 32'h1 : 32'h0);
        set_fwd(0, 1'b0, 1'b0, 5'd9, 32'h77);
        #1 check("lu_we0_stall", {31'b0, bus.stall}, 32'h0);
        check("lu_we0_data", rd(1), 32'h99);

        // 6. younger ready entry masks older not-ready entry
        @(negedge clk);
        set_fwd(0, 1'b1, 1'b1, 5'd4, 32'h55);
        set_fwd(1, 1'b1, 1'b0, 5'd4, 32'h66);
        bus.ren = 2'b01; set_raddr(0, 5'd4); set_raddr(1, 5'd0);
        #1 check("mask_stall", {31'b0, bus.stall}, 32'h0);
        check("mask_data", rd(0), FWD ? 32'h55 : 32'h0);
        set_fwd(0, 1'b0, 1'b1, 5'd4, 32'h55);
        #1 check("older_stall", {31'b0, bus.stall}, FWD ? 32'h1 : 32'h0);
        bus.fwd_bus = '0; bus.ren = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
